// File: rtl/snk68_pkg.sv
// Shared definitions for the SNK68 sound command latch.
// Holds the NMI pulse FSM state encoding and the fixed inter-pulse gap.
// No logic; imported by the latch top level.
package snk68_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } nmi_state_t;

  // High time forced between two NMI pulses so the Z80 sees distinct edges.
  localparam int NMI_GAP_CYCLES = 2;

endpackage

// File: rtl/snk68_edge_det.sv
// 1-bit strobe edge detector: single-cycle rise/fall pulses.
// Latency: pulses are combinational from d against a registered copy (0 cycles).
// Backpressure: none; one pulse per transition regardless of strobe length.
module snk68_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // Previous-cycle copy of the qualifier.
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/snk68_sound_latch.sv
// 68000 <-> Z80 command/reply latch bridge with Z80 NMI pulse generator.
// Latency: latches/flags update 1 cycle after the sampled event; NMI falls 2 cycles after the 68k write.
// Backpressure: none; commands overwrite (or, with SNK68_SNDLATCH_FIFO_EN, queue and drop when full).
module snk68_sound_latch
  import snk68_pkg::*;
#(
  parameter int NMI_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_latch_cs,
  input  logic [15:0] m68k_dout,
  input  logic        z80_latch_read_cs,
  output logic [7:0]  m68k_latch2_dout,
  input  logic        z80_latch_cs,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic [7:0]  z80_dout,
  output logic [7:0]  z80_latch_dout,
  output logic        z80_nmi_n,
  output logic        cmd_pending,
  output logic        reply_valid
);

  localparam int CNT_W = $clog2(NMI_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(NMI_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(NMI_GAP_CYCLES - 1);

  // ---------------- access events ----------------
  logic z80_rd_act, z80_wr_act;
  logic wr68, wr68_fall, rdz, rdz_rise, wrz, wrz_fall, rd68, rd68_rise;

  assign z80_rd_act = z80_latch_cs & ~z80_rd_n;
  assign z80_wr_act = z80_latch_cs & ~z80_wr_n;

  snk68_edge_det u_ed_wr68 (.clk(clk), .reset(reset), .d(m68k_latch_cs),     .rise(wr68),      .fall(wr68_fall));
  snk68_edge_det u_ed_rdz  (.clk(clk), .reset(reset), .d(z80_rd_act),        .rise(rdz_rise),  .fall(rdz));
  snk68_edge_det u_ed_wrz  (.clk(clk), .reset(reset), .d(z80_wr_act),        .rise(wrz),       .fall(wrz_fall));
  snk68_edge_det u_ed_rd68 (.clk(clk), .reset(reset), .d(z80_latch_read_cs), .rise(rd68_rise), .fall(rd68));

  logic nmi_set;   // command path requests an NMI
  logic nmi_take;  // FSM consumes the pending request
  logic nmi_req;

  // ---------------- command path ----------------
`ifdef SNK68_SNDLATCH_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic [7:0]       last_pop;
  logic             fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = rdz & ~fifo_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO is kept then.
  assign push       = wr68 & (~fifo_full | pop);

  // Occupancy: push+pop together leaves the count unchanged.
  always_comb begin
    count_nxt = count;
    if (push & ~pop)      count_nxt = count + 1'b1;
    else if (pop & ~push) count_nxt = count - 1'b1;
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= m68k_dout[15:8];
  end

  // Pointers, count and the last-popped byte shown when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_pop <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        last_pop <= fifo_mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  // Every accepted command, and every pop that leaves work queued, asks for an NMI.
  assign nmi_set        = push | (pop & (count_nxt != '0));
  assign cmd_pending    = ~fifo_empty;
  assign z80_latch_dout = fifo_empty ? last_pop : fifo_mem[rd_ptr];
`else
  logic [7:0] cmd_reg;
  logic       cmd_pend_q;
  logic       unused_fifo_cfg;

  assign unused_fifo_cfg = (FIFO_DEPTH > 0);

  // Single command register; a new write beats a simultaneous read end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_reg    <= 8'h00;
      cmd_pend_q <= 1'b0;
    end else if (wr68) begin
      cmd_reg    <= m68k_dout[15:8];
      cmd_pend_q <= 1'b1;
    end else if (rdz) begin
      cmd_pend_q <= 1'b0;
    end
  end

  assign nmi_set        = wr68;
  assign cmd_pending    = cmd_pend_q;
  assign z80_latch_dout = cmd_reg;
`endif

  // ---------------- reply path ----------------
  logic [7:0] reply_reg;
  logic       reply_vld_q;

  // Reply register; a new Z80 write beats a simultaneous 68k read end.
  always_ff @(posedge clk) begin
    if (reset) begin
      reply_reg   <= 8'h00;
      reply_vld_q <= 1'b0;
    end else if (wrz) begin
      reply_reg   <= z80_dout;
      reply_vld_q <= 1'b1;
    end else if (rd68) begin
      reply_vld_q <= 1'b0;
    end
  end

  assign m68k_latch2_dout = reply_reg;
  assign reply_valid      = reply_vld_q;

  // ---------------- NMI generator ----------------
  nmi_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Pending NMI request; a new request wins over consumption in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)         nmi_req <= 1'b0;
    else if (nmi_set)  nmi_req <= 1'b1;
    else if (nmi_take) nmi_req <= 1'b0;
  end

  // FSM state and shared pulse/gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: low pulse of NMI_CYCLES, then a fixed high gap. A request
  // waiting at the end of the gap starts the next pulse directly, giving the
  // minimum period of NMI_CYCLES + gap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    nmi_take  = 1'b0;
    case (state)
      IDLE: begin
        if (nmi_req) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LOAD;
          nmi_take  = 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (nmi_req) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LOAD;
          nmi_take  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign z80_nmi_n = (state != PULSE);

  logic unused_sig;
  assign unused_sig = &{1'b0, m68k_dout[7:0], wr68_fall, rdz_rise, wrz_fall, rd68_rise};

endmodule

// File: tb/tb_snk68_sound_latch.sv
module tb_snk68_sound_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic        m68k_latch_cs;
  logic [15:0] m68k_dout;
  logic        z80_latch_read_cs;
  logic [7:0]  m68k_latch2_dout;
  logic        z80_latch_cs;
  logic        z80_rd_n;
  logic        z80_wr_n;
  logic [7:0]  z80_dout;
  logic [7:0]  z80_latch_dout;
  logic        z80_nmi_n;
  logic        cmd_pending;
  logic        reply_valid;

  int checks   = 0;
  int failures = 0;

  snk68_sound_latch #(.NMI_CYCLES(16), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .m68k_latch_cs    (m68k_latch_cs),
    .m68k_dout        (m68k_dout),
    .z80_latch_read_cs(z80_latch_read_cs),
    .m68k_latch2_dout (m68k_latch2_dout),
    .z80_latch_cs     (z80_latch_cs),
    .z80_rd_n         (z80_rd_n),
    .z80_wr_n         (z80_wr_n),
    .z80_dout         (z80_dout),
    .z80_latch_dout   (z80_latch_dout),
    .z80_nmi_n        (z80_nmi_n),
    .cmd_pending      (cmd_pending),
    .reply_valid      (reply_valid)
  );

  always #5 clk = ~clk;

  // NMI pulse monitor, sampled 1 time unit after each rising edge.
  int   pulses, bad_len, last_len, cur_len, high_run, min_gap;
  logic prev_nmi = 1'b1;

  always begin
    @(posedge clk);
    #1;
    if (!z80_nmi_n) begin
      if (prev_nmi) begin
        pulses++;
        if (pulses > 1 && high_run < min_gap) min_gap = high_run;
        cur_len = 0;
      end
      cur_len++;
    end else begin
      if (!prev_nmi) begin
        last_len = cur_len;
        if (cur_len != 16) bad_len++;
        high_run = 0;
      end
      high_run++;
    end
    prev_nmi = z80_nmi_n;
  end

  task automatic clear_mon();
    pulses   = 0;
    bad_len  = 0;
    last_len = 0;
    cur_len  = 0;
    high_run = 0;
    min_gap  = 999;
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic m68k_write(input logic [15:0] d);
    m68k_latch_cs = 1'b1;
    m68k_dout     = d;
    tick();
    m68k_latch_cs = 1'b0;
  endtask

  task automatic z80_read(input string tag, input logic [7:0] exp);
    z80_latch_cs = 1'b1;
    z80_rd_n     = 1'b0;
    tick();
    tick();
    check_val(tag, {24'h0, z80_latch_dout}, {24'h0, exp});
    z80_latch_cs = 1'b0;
    z80_rd_n     = 1'b1;
    tick();
  endtask

  task automatic z80_write(input logic [7:0] d);
    z80_latch_cs = 1'b1;
    z80_wr_n     = 1'b0;
    z80_dout     = d;
    tick();
    z80_latch_cs = 1'b0;
    z80_wr_n     = 1'b1;
  endtask

  initial begin
    reset             = 1'b1;
    m68k_latch_cs     = 1'b0;
    m68k_dout         = 16'h0000;
    z80_latch_read_cs = 1'b0;
    z80_latch_cs      = 1'b0;
    z80_rd_n          = 1'b1;
    z80_wr_n          = 1'b1;
    z80_dout          = 8'h00;
    clear_mon();
    wait_ticks(3);
    reset = 1'b0;
    tick();

    // Reset state
    check_val("rst_nmi_n",   {31'h0, z80_nmi_n},   32'h1);
    check_val("rst_pending", {31'h0, cmd_pending}, 32'h0);
    check_val("rst_reply_v", {31'h0, reply_valid}, 32'h0);
    check_val("rst_cmd_out", {24'h0, z80_latch_dout},   32'h0);
    check_val("rst_rep_out", {24'h0, m68k_latch2_dout}, 32'h0);

    // Basic command
    clear_mon();
    m68k_write(16'h5A00);
    check_val("basic_cmd",     {24'h0, z80_latch_dout}, 32'h5A);
    check_val("basic_pending", {31'h0, cmd_pending},    32'h1);
    check_val("basic_nmi_hi1", {31'h0, z80_nmi_n},      32'h1);
    tick();
    check_val("basic_nmi_fall", {31'h0, z80_nmi_n},     32'h0);
    wait_ticks(30);
    check_val("basic_pulses",  pulses,   32'd1);
    check_val("basic_len",     last_len, 32'd16);
    z80_read("basic_z80_rd", 8'h5A);
    check_val("basic_pend_clr", {31'h0, cmd_pending}, 32'h0);

`ifndef SNK68_SNDLATCH_FIFO_EN
    // Back-to-back writes three cycles apart
    clear_mon();
    m68k_write(16'h1100);
    tick();
    tick();
    m68k_write(16'h2200);
    wait_ticks(60);
    check_val("b2b_pulses",  pulses,  32'd2);
    check_val("b2b_bad_len", bad_len, 32'd0);
    check_val("b2b_gap_ge2", {31'h0, (min_gap >= 2)}, 32'h1);
    check_val("b2b_cmd",     {24'h0, z80_latch_dout}, 32'h22);
    z80_read("b2b_z80_rd", 8'h22);
    check_val("b2b_pend_clr", {31'h0, cmd_pending}, 32'h0);

    // 68k write and Z80 read end in the same cycle: write wins
    z80_latch_cs = 1'b1;
    z80_rd_n     = 1'b0;
    tick();
    tick();
    z80_latch_cs  = 1'b0;
    z80_rd_n      = 1'b1;
    m68k_latch_cs = 1'b1;
    m68k_dout     = 16'h7700;
    tick();
    m68k_latch_cs = 1'b0;
    check_val("sim_cmd_pending", {31'h0, cmd_pending},    32'h1);
    check_val("sim_cmd_data",    {24'h0, z80_latch_dout}, 32'h77);
    wait_ticks(40);
`endif

    // Reply path
    z80_write(8'hC3);
    check_val("reply_valid", {31'h0, reply_valid},      32'h1);
    check_val("reply_data",  {24'h0, m68k_latch2_dout}, 32'hC3);
    z80_latch_read_cs = 1'b1;
    tick();
    check_val("reply_hold", {31'h0, reply_valid}, 32'h1);
    z80_latch_read_cs = 1'b0;
    tick();
    check_val("reply_clr", {31'h0, reply_valid}, 32'h0);

    // New Z80 write coinciding with the end of a 68k read: write wins
    z80_write(8'hA5);
    tick();
    z80_latch_read_cs = 1'b1;
    tick();
    z80_latch_read_cs = 1'b0;
    z80_latch_cs      = 1'b1;
    z80_wr_n          = 1'b0;
    z80_dout          = 8'h3C;
    tick();
    z80_latch_cs = 1'b0;
    z80_wr_n     = 1'b1;
    check_val("sim_reply_valid", {31'h0, reply_valid},      32'h1);
    check_val("sim_reply_data",  {24'h0, m68k_latch2_dout}, 32'h3C);
    z80_latch_read_cs = 1'b1;
    tick();
    z80_latch_read_cs = 1'b0;
    tick();
    check_val("sim_reply_clr", {31'h0, reply_valid}, 32'h0);

    // Long strobe: one event, one NMI
    clear_mon();
    m68k_latch_cs = 1'b1;
    m68k_dout     = 16'h9900;
    wait_ticks(10);
    m68k_latch_cs = 1'b0;
    wait_ticks(40);
    check_val("long_pulses",  pulses,  32'd1);
    check_val("long_bad_len", bad_len, 32'd0);
    check_val("long_cmd",     {24'h0, z80_latch_dout}, 32'h99);

    // Reset during the fifth low cycle of a pulse
    z80_write(8'hE1);
    m68k_write(16'h4400);
    tick();
    wait_ticks(4);
    check_val("mid_nmi_low", {31'h0, z80_nmi_n}, 32'h0);
    reset = 1'b1;
    tick();
    check_val("mid_rst_nmi_n",   {31'h0, z80_nmi_n},   32'h1);
    check_val("mid_rst_pending", {31'h0, cmd_pending}, 32'h0);
    check_val("mid_rst_reply_v", {31'h0, reply_valid}, 32'h0);
    check_val("mid_rst_cmd",     {24'h0, z80_latch_dout}, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    clear_mon();
    wait_ticks(30);
    check_val("mid_no_pulse", pulses, 32'd0);

`ifdef SNK68_SNDLATCH_FIFO_EN
    // FIFO: fifth push is dropped, pops come out in order
    begin
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
      for (int i = 0; i < 5; i++) begin
        m68k_write({8'h11 * 8'(i + 1), 8'h00});
        tick();
      end
      check_val("fifo_pending", {31'h0, cmd_pending},    32'h1);
      check_val("fifo_head",    {24'h0, z80_latch_dout}, 32'h11);
      wait_ticks(80);
      clear_mon();
      for (int i = 0; i < 4; i++) begin
        z80_read($sformatf("fifo_rd%0d", i), exp_b[i]);
        wait_ticks(40);
        check_val($sformatf("fifo_nmi%0d", i), pulses, (i < 3) ? 32'd1 : 32'd0);
        clear_mon();
      end
      check_val("fifo_empty",    {31'h0, cmd_pending},    32'h0);
      check_val("fifo_last_pop", {24'h0, z80_latch_dout}, 32'h44);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
